// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that walks a WIDTH-bit operand pair
// one CHUNK-bit slice per cycle, LSB first, with the carry held in a register
// between slices.
//
// Parameters
//   WIDTH     operand/result width (multiple of CHUNK)
//   CHUNK     bits processed per cycle; NCHUNK = WIDTH / CHUNK cycles per op
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request an operation (honoured in IDLE or DONE only)
//   sub        in   0: a + b, 1: a - b (sampled with start)
//   a, b       in   operands (sampled with start)
//   busy       out  high while slices are being processed
//   done       out  one-cycle pulse when res/carry_out/overflow update
//   res        out  result, held until the next done
//   carry_out  out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out  two's-complement signed overflow
module seq_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    // Keep the index at least one bit wide so NCHUNK = 1 still elaborates.
    localparam int unsigned IdxW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Slice datapath
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] acc_wr;

    // Select slice idx_q of both operands. Constant part-selects inside the
    // loop keep the mux explicit and width-clean.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IdxW'(k)) begin
                a_slice = a_q[k*CHUNK +: CHUNK];
                b_slice = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // CHUNK+1-bit slice adder; the top bit is the carry into the next slice.
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};

    // Accumulator with the current slice sum merged in. On the last slice
    // this is exactly {s, lower slices of acc}, i.e. the final result.
    always_comb begin
        acc_wr = acc_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IdxW'(k)) begin
                acc_wr[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert b here, seed carry with 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end

            StRun: begin
                acc_d   = acc_wr;
                carry_d = slice_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    res_d   = acc_wr;
                    cout_d  = slice_sum[CHUNK];
                    // Same-signed inputs producing a different-signed result.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign res       = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

    localparam int N32 = 4;
    localparam int N16 = 4;

    logic clk;
    logic rst_n;

    // Default instance (32/8)
    logic        start, sub, busy, done, cout, ovf;
    logic [31:0] a, b, res;
    // 16/4 instance
    logic        start16, sub16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, res16;
    // 8/8 instance (single slice)
    logic        start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, res8;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_res;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .carry_out(cout), .overflow(ovf)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .res(res16), .carry_out(cout16), .overflow(ovf16)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .res(res8), .carry_out(cout8), .overflow(ovf8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word arithmetic reference: unsigned sum/difference for result and
    // carry, signed integer range test for overflow.
    function automatic void model(input int w, input logic [63:0] x_in, input logic [63:0] y_in,
                                  input bit s, output logic [63:0] r, output logic c,
                                  output logic v);
        logic [63:0] m;
        logic [63:0] x, y;
        longint sx, sy, rs, hi, lo;
        m = (64'd1 << w) - 64'd1;
        x = x_in & m;
        y = y_in & m;
        if (!s) begin
            r = (x + y) & m;
            c = ((x + y) >> w) != 64'd0;
        end else begin
            r = (x - y) & m;
            c = (x >= y);
        end
        sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        rs = s ? sx - sy : sx + sy;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        v  = (rs > hi) || (rs < lo);
    endfunction

    // Issue one op on the 32-bit instance and check the full handshake.
    // Called #1 after a clock edge; returns #1 after the edge that enters DONE.
    // poke: pulse start with fresh operands mid-RUN (must be ignored).
    task automatic op(input logic [31:0] x, input logic [31:0] y, input bit s, input bit poke,
                      input string tag);
        logic [63:0] er;
        logic ec, ev;
        model(32, {32'd0, x}, {32'd0, y}, s, er, ec, ev);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < N32; i++) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            check({tag, " done early"}, 64'(done), 64'd0);
            check({tag, " res held"}, 64'(res), 64'(prev_res));
            if (poke && i == 1) begin
                start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            end
            if (poke && i == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy off"}, 64'(busy), 64'd0);
        check({tag, " res"}, 64'(res), er & 64'hFFFF_FFFF);
        check({tag, " carry_out"}, 64'(cout), 64'(ec));
        check({tag, " overflow"}, 64'(ovf), 64'(ev));
        prev_res = er[31:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle done", 64'(done), 64'd0);
            check("idle busy", 64'(busy), 64'd0);
            check("idle res", 64'(res), 64'(prev_res));
        end
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input bit s);
        logic [63:0] er;
        logic ec, ev;
        model(16, {48'd0, x}, {48'd0, y}, s, er, ec, ev);
        a16 = x; b16 = y; sub16 = s; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int i = 0; i < N16; i++) begin
            check("w16 busy", 64'(busy16), 64'd1);
            check("w16 done early", 64'(done16), 64'd0);
            @(posedge clk); #1;
        end
        check("w16 done", 64'(done16), 64'd1);
        check("w16 res", 64'(res16), er);
        check("w16 carry_out", 64'(cout16), 64'(ec));
        check("w16 overflow", 64'(ovf16), 64'(ev));
        @(posedge clk); #1;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s);
        logic [63:0] er;
        logic ec, ev;
        model(8, {56'd0, x}, {56'd0, y}, s, er, ec, ev);
        a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("w8 busy", 64'(busy8), 64'd1);
        check("w8 done early", 64'(done8), 64'd0);
        @(posedge clk); #1;
        check("w8 done", 64'(done8), 64'd1);
        check("w8 res", 64'(res8), er);
        check("w8 carry_out", 64'(cout8), 64'(ec));
        check("w8 overflow", 64'(ovf8), 64'(ev));
        @(posedge clk); #1;
    endtask

    initial begin
        start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        prev_res = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset res", 64'(res), 64'd0);
        check("reset carry_out", 64'(cout), 64'd0);
        check("reset overflow", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "wrap");      idle(1);
        op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "ovf add");   idle(1);
        op(32'h8000_0000, 32'h1, 1'b1, 1'b0, "ovf sub");   idle(1);
        op(32'd5, 32'd7, 1'b1, 1'b0, "borrow");            idle(1);
        op(32'd7, 32'd5, 1'b1, 1'b0, "no borrow");         idle(2);

        // start mid-RUN is ignored, then a back-to-back start in DONE
        op($urandom, $urandom, 1'b0, 1'b1, "ignore");
        op(32'd3, 32'd4, 1'b0, 1'b0, "b2b");
        idle(1);

        // Random mix of back-to-back and idle-separated operations
        for (int i = 0; i < 24; i++) begin
            op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        // Reset two cycles into RUN
        op(32'd1, 32'd1, 1'b0, 1'b0, "pre reset");
        a = 32'h1234_5678; b = 32'h0FED_CBA9; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst res", 64'(res), 64'd0);
        check("midrst carry_out", 64'(cout), 64'd0);
        check("midrst overflow", 64'(ovf), 64'd0);
        prev_res = '0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idle(6);
        op(32'h10, 32'h20, 1'b0, 1'b0, "post reset");
        idle(1);

        // Other parametrisations
        op16(16'h0FFF, 16'h0001, 1'b0);
        op8(8'h80, 8'h01, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle integer adder/subtractor that processes a WIDTH-bit operand pair one CHUNK-bit slice per cycle, LSB first, with a ripple carry held between slices. It extends the team's byte-serial 32-bit adder in three ways: configurable width and slice size, a subtract mode, and separate unsigned carry-out and signed overflow flags. It also adds a start/busy/done handshake. It sits in the `verilog_sim` arithmetic path wherever area matters more than latency.

## Interface
- `WIDTH`, default 32: operand and result width; must be a multiple of `CHUNK`.
- `CHUNK`, default 8: bits added per cycle; `NCHUNK = WIDTH/CHUNK` (NCHUNK = 1 is legal).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request a new operation; sampled only in IDLE or DONE.
- `sub`  in  1: 0 = `a + b`, 1 = `a - b`; sampled with `start`.
- `a`, `b`  in  WIDTH: operands; sampled with `start`; may change afterwards.
- `busy`  out  1: high while slices are being processed (RUN).
- `done`  out  1: single-cycle pulse when `res` and the flags update.
- `res`  out  WIDTH: result; holds its value until the next `done`.
- `carry_out`  out  1: raw carry out of the MSB (for subtract, 1 = no borrow, i.e. `a >= b` unsigned).
- `overflow`  out  1: two's-complement signed overflow of the operation.

## Operation
- **States:** IDLE, RUN, DONE; the encoding is one-hot or binary, and illegal encodings return to IDLE.
- **Accepting a request:** in IDLE or DONE with `start = 1`, the block latches the following and moves to RUN:
  - `a` into `a_q`;
  - `b ^ {WIDTH{sub}}` into `b_q`;
  - `sub` into the carry register;
  - 0 into the slice index and into `acc`.
- **RUN:** each cycle computes `{c, s} = {1'b0, a_q[k]} + {1'b0, b_q[k]} + carry`, where slice k = bits `[k*CHUNK +: CHUNK]`.
  - Writes `s` into slice k of `acc`, sets `carry <= c`, and increments k.
  - When k = NCHUNK-1, the block moves to DONE and commits:
    - `res <= {s, acc lower slices}`;
    - `carry_out <= c`;
    - `overflow <= (a_q[MSB] == b_q[MSB]) && (s[CHUNK-1] != a_q[MSB])`.
- **DONE:** lasts one cycle with `done = 1`. It goes to RUN if `start = 1` (back-to-back), otherwise to IDLE.
- **start during RUN:** ignored and not queued; operands are not re-sampled.
- **Register ownership:** `res`, `carry_out` and `overflow` change only at the RUN→DONE edge. Partial results never appear on `res`.
- **Width rules:**
  - Result wraps modulo 2^WIDTH.
  - The slice adder is CHUNK+1 bits wide.
  - No sign extension; the same datapath serves signed and unsigned operands.

## Timing
- **Reset values** (asynchronous on `rst_n = 0`, immediate):
  - state = IDLE;
  - `busy = 0`, `done = 0`;
  - `res = 0`, `carry_out = 0`, `overflow = 0`;
  - internal carry, index and `acc` = 0.
- **Reset mid-operation:** the operation is discarded and no `done` is produced. After `rst_n` is released, the first rising edge with `start = 1` begins a fresh operation.
- **Latency:** `start` is sampled at edge E0.
  - `busy = 1` from after E0 until after E_NCHUNK (exactly NCHUNK cycles).
  - `done = 1` for the single cycle after E_NCHUNK.
  - Start-to-done is NCHUNK+1 edges (5 for the defaults).
- **Throughput:** one operation per NCHUNK+1 cycles with `start` held high. A start accepted in DONE gives `busy` high on the very next cycle.
- **Output decode:** `busy` and `done` are decoded directly from the state register, with no combinational path from `start`.
- **Flag stability:** `res` and the flags are stable from the cycle `done` rises until the next `done`, including across IDLE.

## Test plan
- **Unsigned wrap:** defaults; `a = 0xFFFFFFFF`, `b = 0x00000001`, `sub = 0`. Expect:
  - `done` exactly 5 edges after start, with `busy` high for 4 cycles;
  - `res = 0x00000000`, `carry_out = 1`, `overflow = 0`.
- **Signed overflow:**
  - Add: `a = 0x7FFFFFFF`, `b = 1` → `res = 0x80000000`, `overflow = 1`, `carry_out = 0`.
  - Subtract: `a = 0x80000000`, `b = 1`, `sub = 1` → `res = 0x7FFFFFFF`, `overflow = 1`, `carry_out = 1`.
- **Borrow:** `a = 5`, `b = 7`, `sub = 1` → `res = 0xFFFFFFFE`, `carry_out = 0`, `overflow = 0`. Then `a = 7`, `b = 5` → `res = 2`, `carry_out = 1`.
- **Handshake:**
  - Pulse `start` with new operands mid-RUN → ignored; the result matches the original operands.
  - Hold `start` high in the DONE cycle with `a = 3`, `b = 4` → next `done` 5 cycles later with `res = 7`.
  - `res` is unchanged between the two `done` pulses.
- **Reset mid-operation:** drop `rst_n` two cycles into RUN. Expect:
  - `busy`, `done`, `res` and the flags go to 0 immediately;
  - no `done` after release;
  - a subsequent `0x10 + 0x20` gives `res = 0x30`.
- **Parametrisation:**
  - `WIDTH = 16`, `CHUNK = 4`: `0x0FFF + 0x0001` → `res = 0x1000` with `done` 5 edges after start (NCHUNK = 4).
  - `WIDTH = CHUNK = 8`: `0x80 - 0x01` → `res = 0x7F`, `overflow = 1`, `done` 2 edges after start.
